instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the control-unit decode path: turns a decoded instruction (class, ALUControl-style op, regs, imm)
//  into an RV32I word and loads it into instruction memory. Encoded words are buffered in a FIFO and written
//  to consecutive word addresses from a base. Used by bring-up/self-test logic to build programs in IMEM.
// PARAMETERS
//  DEPTH       4   FIFO entries (power of 2, >=2)
//  ADDR_WIDTH  12  IMEM byte-address width; writes step by 4
// PORTS
//  clk_i       in   1   clock; all state on rising edge
//  rst_ni      in   1   async active-low reset
//  start_i     in   1   pulse: latch base_i, clear addr/err, enter RUN
//  base_i      in   ADDR_WIDTH  first write address; bits[1:0] forced to 0
//  valid_i     in   1   instruction fields valid
//  ready_o     out  1   encoder can accept (RUN and FIFO not full)
//  last_i      in   1   with valid_i: final instruction of program
//  class_i     in   3   0 R,1 I-arith,2 LOAD,3 STORE,4 BRANCH,5 JAL,6 JALR,7 LUI
//  alu_i       in   3   R/I-arith op: 000 ADD,001 SUB,010 AND,011 OR,101 SLT,110 SLL
//  funct3_i    in   3   funct3 for LOAD/STORE/BRANCH; ignored otherwise
//  rd_i/rs1_i/rs2_i in 5 each  register indices
//  imm_i       in   32  signed immediate; LUI uses imm_i[31:12]
//  we_o        out  1   IMEM write strobe
//  addr_o      out  ADDR_WIDTH  IMEM write address
//  wdata_o     out  32  encoded instruction
//  wr_ready_i  in   1   IMEM accepts write this cycle
//  busy_o      out  1   state != IDLE/DONE
//  done_o      out  1   high in DONE until next start_i
//  err_o       out  1   sticky: an instruction was rejected
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, ready_o/we_o/busy_o/done_o/err_o=0, addr_o=0, wdata_o=0.
//  FSM: IDLE -start_i-> RUN; RUN -accept with last_i-> DRAIN; DRAIN -FIFO empty and last write done-> DONE;
//   DONE -start_i-> RUN. start_i in RUN/DRAIN ignored. Valid/accept only in RUN.
//  Accept = valid_i & ready_o. Encoding is combinational; word enters FIFO on accept edge.
//  Encodings (opcode): R 0110011, funct7=0100000 for SUB else 0; I 0010011 (SLLI imm[11:5]=0, shamt=imm[4:0]);
//   LOAD 0000011 I-format; STORE 0100011 S-format; BRANCH 1100011 B-format imm[12:1];
//   JAL 1101111 J-format imm[20:1]; JALR 1100111 funct3=000; LUI 0110111.
//  ALU->funct3: ADD/SUB 000, SLL 001, SLT 010, OR 110, AND 111.
//  Reject (accepted, NOT enqueued, err_o<=1): alu_i 100/111; SUB with I-arith; any alu_i!=ADD/SUB/AND/OR/SLT/SLL;
//   imm outside signed range (I/S 12b, B 13b, J 21b); B/J imm[0]!=0; SLLI imm outside 0..31; LUI imm[11:0]!=0.
//   Rejected last_i still moves to DRAIN.
//  Write port: we_o=1 whenever FIFO non-empty, wdata_o=head, addr_o=current addr. On we_o&wr_ready_i: pop,
//   addr+=4 (wraps modulo 2^ADDR_WIDTH). we_o held stable while wr_ready_i=0. Accept->earliest we_o: 1 cycle.
//  Full: ready_o=0; simultaneous push and pop when full not permitted (ready_o already 0). Push+pop when
//   non-full/non-empty: count unchanged.
//  start_i: addr<=base_i&~3, err_o<=0, done_o<=0. rst_ni low mid-run: immediate abort, FIFO discarded.
// TESTING
//  start base 0x100; ADD x3,x1,x2 -> we_o, addr 0x100, wdata 0x002081B3.
//  SUB x5,x6,x7 then ADDI x1,x0,5 -> 0x407302B3 @0x100, 0x00500093 @0x104.
//  BNE x1,x2,imm -8 (funct3 001) -> 0xFE209CE3; JAL x1, imm 2048 (last_i) -> 0x001000EF, then done_o=1.
//  Hold wr_ready_i=0, push DEPTH words -> ready_o=0 after DEPTH accepts; release -> words in order, addr+4 each.
//  ADDI imm 4096 -> nothing written, err_o=1 sticky; next start_i clears err_o.
//  Assert rst_ni low with FIFO holding 2 words -> we_o=0, FIFO empty, state IDLE, no further writes.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / IMEM loader.
// Encodes decoded instruction fields into RV32I words, buffers them in a small FIFO and
// writes them to consecutive IMEM word addresses starting at a latched base address.
module instr_encoder_loader #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic [2:0]            class_i,
    input  logic [2:0]            alu_i,
    input  logic [2:0]            funct3_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [31:0]           imm_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    input  logic                  wr_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] ClsR      = 3'd0;
    localparam logic [2:0] ClsIArith = 3'd1;
    localparam logic [2:0] ClsLoad   = 3'd2;
    localparam logic [2:0] ClsStore  = 3'd3;
    localparam logic [2:0] ClsBranch = 3'd4;
    localparam logic [2:0] ClsJal    = 3'd5;
    localparam logic [2:0] ClsJalr   = 3'd6;
    localparam logic [2:0] ClsLui    = 3'd7;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;
    localparam logic [2:0] AluSll = 3'b110;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;
    logic [31:0]           mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;

    logic        alu_ok;
    logic [2:0]  alu_f3;
    logic        enc_ok;
    logic [31:0] enc_word;
    logic        fits12, fits13, fits21;
    logic        fifo_full, fifo_empty;
    logic        accept, push, pop, start_ok;

    // Low address bits are forced to zero, so they never reach any logic.
    logic unused_base;
    assign unused_base = ^base_i[1:0];

    // Sign-extension checks: all bits above the field's sign bit must match it.
    assign fits12 = (imm_i[31:11] == '0) | (imm_i[31:11] == '1);
    assign fits13 = (imm_i[31:12] == '0) | (imm_i[31:12] == '1);
    assign fits21 = (imm_i[31:20] == '0) | (imm_i[31:20] == '1);

    // Map the ALUControl-style op onto an RV32I funct3 and flag unsupported ops.
    always_comb begin
        alu_ok = 1'b1;
        alu_f3 = 3'b000;
        case (alu_i)
            AluAdd, AluSub: alu_f3 = 3'b000;
            AluAnd:         alu_f3 = 3'b111;
            AluOr:          alu_f3 = 3'b110;
            AluSlt:         alu_f3 = 3'b010;
            AluSll:         alu_f3 = 3'b001;
            default:        alu_ok = 1'b0;
        endcase
    end

    // Build the instruction word and decide whether it is encodable.
    always_comb begin
        enc_ok   = 1'b1;
        enc_word = '0;
        case (class_i)
            ClsR: begin
                enc_ok   = alu_ok;
                enc_word = {(alu_i == AluSub) ? 7'b0100000 : 7'b0000000,
                            rs2_i, rs1_i, alu_f3, rd_i, OpcR};
            end
            ClsIArith: begin
                if (alu_i == AluSll) begin
                    enc_ok   = (imm_i[31:5] == '0);
                    enc_word = {7'b0000000, imm_i[4:0], rs1_i, alu_f3, rd_i, OpcImm};
                end else begin
                    enc_ok   = alu_ok & (alu_i != AluSub) & fits12;
                    enc_word = {imm_i[11:0], rs1_i, alu_f3, rd_i, OpcImm};
                end
            end
            ClsLoad: begin
                enc_ok   = fits12;
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OpcLoad};
            end
            ClsStore: begin
                enc_ok   = fits12;
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OpcStore};
            end
            ClsBranch: begin
                enc_ok   = fits13 & ~imm_i[0];
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OpcBranch};
            end
            ClsJal: begin
                enc_ok   = fits21 & ~imm_i[0];
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OpcJal};
            end
            ClsJalr: begin
                enc_ok   = fits12;
                enc_word = {imm_i[11:0], rs1_i, 3'b000, rd_i, OpcJalr};
            end
            ClsLui: begin
                enc_ok   = (imm_i[11:0] == '0);
                enc_word = {imm_i[31:12], rd_i, OpcLui};
            end
            default: ;
        endcase
    end

    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    assign ready_o  = (state_q == StRun) & ~fifo_full;
    assign accept   = valid_i & ready_o;
    // Rejected instructions are still consumed, they just never reach the FIFO.
    assign push     = accept & enc_ok;
    assign we_o     = ~fifo_empty;
    assign pop      = we_o & wr_ready_i;
    assign start_ok = start_i & ((state_q == StIdle) | (state_q == StDone));

    assign addr_o  = addr_q;
    assign wdata_o = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign busy_o  = (state_q == StRun) | (state_q == StDrain);
    assign done_o  = (state_q == StDone);
    assign err_o   = err_q;

    // Next-state logic for the load sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun:   if (accept && last_i) state_d = StDrain;
            StDrain: if (fifo_empty) state_d = StDone;
            StDone:  if (start_ok) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State, address, sticky error and FIFO pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (start_ok) begin
                addr_q <= {base_i[ADDR_WIDTH-1:2], 2'b00};
            end else if (pop) begin
                addr_q <= addr_q + ADDR_WIDTH'(4);
            end
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (accept && !enc_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed spec vectors plus randomized instructions
// checked against an independent encoding model and a queue of expected IMEM writes.
module tb_instr_encoder_loader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_i;
    logic          valid_i;
    logic          ready_o;
    logic          last_i;
    logic [2:0]    class_i, alu_i, funct3_i;
    logic [4:0]    rd_i, rs1_i, rs2_i;
    logic [31:0]   imm_i;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          wr_ready_i;
    logic          busy_o, done_o, err_o;

    logic rand_mode = 1'b0;
    logic fixed_ready = 1'b0;
    logic rnd_ready = 1'b0;
    assign wr_ready_i = rand_mode ? rnd_ready : fixed_ready;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] exp_addr;
    bit            exp_err;
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .base_i     (base_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .last_i     (last_i),
        .class_i    (class_i),
        .alu_i      (alu_i),
        .funct3_i   (funct3_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .wdata_o    (wdata_o),
        .wr_ready_i (wr_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    always begin
        @(posedge clk_i);
        #2;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    // Every write the DUT commits must match the head of the expected-write queue.
    always @(negedge clk_i) begin
        if (rst_ni && we_o && wr_ready_i) begin
            checks++;
            if (exp_data_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", addr_o, wdata_o);
            end else begin
                logic [AW-1:0] ea;
                logic [31:0]   ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (addr_o !== ea || wdata_o !== ed) begin
                    errors++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             addr_o, wdata_o, ea, ed);
                end
            end
        end
    end

    function automatic logic [31:0] bits(input logic [31:0] u, input int hi, input int lo);
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference encoder: field placement and legality straight from the RV32I formats.
    function automatic void ref_encode(input int cls, input int alu, input int f3, input int rd,
                                       input int rs1, input int rs2, input int imm,
                                       output bit ok, output logic [31:0] w);
        logic [31:0] u;
        logic [31:0] r1, r2, d, f;
        int  fa;
        bit  alu_good;
        bit  in12;
        u  = imm;
        r1 = 32'(rs1) << 15;
        r2 = 32'(rs2) << 20;
        d  = 32'(rd) << 7;
        f  = 32'(f3) << 12;
        in12 = (imm >= -2048 && imm <= 2047);
        alu_good = 1;
        case (alu)
            0, 1:    fa = 0;
            2:       fa = 7;
            3:       fa = 6;
            5:       fa = 2;
            6:       fa = 1;
            default: begin fa = 0; alu_good = 0; end
        endcase
        ok = 1;
        w  = 0;
        case (cls)
            0: begin
                ok = alu_good;
                w = ((alu == 1) ? 32'h4000_0000 : 32'h0) | r2 | r1 | (32'(fa) << 12) | d | 32'h33;
            end
            1: begin
                if (alu == 6) begin
                    ok = (imm >= 0 && imm <= 31);
                    w = (bits(u, 4, 0) << 20) | r1 | (32'd1 << 12) | d | 32'h13;
                end else begin
                    ok = alu_good && (alu != 1) && in12;
                    w = (bits(u, 11, 0) << 20) | r1 | (32'(fa) << 12) | d | 32'h13;
                end
            end
            2: begin
                ok = in12;
                w = (bits(u, 11, 0) << 20) | r1 | f | d | 32'h03;
            end
            3: begin
                ok = in12;
                w = (bits(u, 11, 5) << 25) | r2 | r1 | f | (bits(u, 4, 0) << 7) | 32'h23;
            end
            4: begin
                ok = (imm >= -4096 && imm <= 4095) && (imm % 2 == 0);
                w = (bits(u, 12, 12) << 31) | (bits(u, 10, 5) << 25) | r2 | r1 | f |
                    (bits(u, 4, 1) << 8) | (bits(u, 11, 11) << 7) | 32'h63;
            end
            5: begin
                ok = (imm >= -1048576 && imm <= 1048575) && (imm % 2 == 0);
                w = (bits(u, 20, 20) << 31) | (bits(u, 10, 1) << 21) | (bits(u, 11, 11) << 20) |
                    (bits(u, 19, 12) << 12) | d | 32'h6F;
            end
            6: begin
                ok = in12;
                w = (bits(u, 11, 0) << 20) | r1 | d | 32'h67;
            end
            default: begin
                ok = (bits(u, 11, 0) == 0);
                w = (u & 32'hFFFF_F000) | d | 32'h37;
            end
        endcase
    endfunction

    task automatic send(input int cls, input int alu, input int f3, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last, input bit exp_ok,
                        input logic [31:0] exp_w);
        int n;
        class_i  = 3'(cls);
        alu_i    = 3'(alu);
        funct3_i = 3'(f3);
        rd_i     = 5'(rd);
        rs1_i    = 5'(rs1);
        rs2_i    = 5'(rs2);
        imm_i    = imm;
        last_i   = last;
        valid_i  = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!ready_o) begin
            errors++;
            $display("FAIL send_ready_timeout: ready_o=%b, required 1", ready_o);
        end else if (exp_ok) begin
            exp_addr_q.push_back(exp_addr);
            exp_data_q.push_back(exp_w);
            exp_addr = exp_addr + AW'(4);
        end else begin
            exp_err = 1;
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        base_i  = base;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        exp_addr = base & 12'hFFC;
        exp_err  = 0;
        checks++;
        if (busy_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b0 || addr_o !== exp_addr) begin
            errors++;
            $display("FAIL start: busy=%b err=%b done=%b addr=%h, required 1 0 0 %h",
                     busy_o, err_o, done_o, addr_o, exp_addr);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!done_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b, required 1 0", name, done_o, busy_o);
        end
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: pending=%0d, required 0", name, exp_data_q.size());
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        start_i = 0; base_i = 0; valid_i = 0; last_i = 0;
        class_i = 0; alu_i = 0; funct3_i = 0; rd_i = 0; rs1_i = 0; rs2_i = 0; imm_i = 0;
        fixed_ready = 1'b1;
        #23;
        checks++;
        if (ready_o !== 0 || we_o !== 0 || busy_o !== 0 || done_o !== 0 || err_o !== 0 ||
            addr_o !== 0 || wdata_o !== 0) begin
            errors++;
            $display("FAIL reset: ready=%b we=%b busy=%b done=%b err=%b addr=%h wdata=%h, required all 0",
                     ready_o, we_o, busy_o, done_o, err_o, addr_o, wdata_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 0 || busy_o !== 0) begin
            errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b, required 0 0", ready_o, busy_o);
        end
    endtask

    task automatic test_directed;
        fixed_ready = 1'b1;
        do_start(12'h100);
        send(0, 0, 0, 3, 1, 2, 0, 0, 1, 32'h002081B3);
        checks++;
        if (we_o !== 1'b1 || addr_o !== 12'h100 || wdata_o !== 32'h002081B3) begin
            errors++;
            $display("FAIL add_first_write: we=%b addr=%h wdata=%h, required 1 100 002081b3",
                     we_o, addr_o, wdata_o);
        end
        send(0, 1, 0, 5, 6, 7, 0, 0, 1, 32'h407302B3);
        send(1, 0, 0, 1, 0, 0, 5, 0, 1, 32'h00500093);
        send(4, 0, 1, 0, 1, 2, -8, 0, 1, 32'hFE209CE3);
        send(5, 0, 0, 1, 0, 0, 2048, 1, 1, 32'h001000EF);
        wait_done("directed");
        checks++;
        if (err_o !== 1'b0 || addr_o !== 12'h114) begin
            errors++;
            $display("FAIL directed_end: err=%b addr=%h, required 0 114", err_o, addr_o);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [31:0] w;
        fixed_ready = 1'b0;
        do_start(12'h202);
        for (int k = 0; k < DEPTH; k++) begin
            ref_encode(0, 2, 0, k + 1, k + 2, k + 3, 0, ok, w);
            send(0, 2, 0, k + 1, k + 2, k + 3, 0, 0, ok, w);
            checks++;
            if (ready_o !== ((k + 1) < DEPTH)) begin
                errors++;
                $display("FAIL full_ready_%0d: ready=%b, required %b", k, ready_o, (k + 1) < DEPTH);
            end
        end
        repeat (3) begin
            @(negedge clk_i);
            checks++;
            if (we_o !== 1'b1 || addr_o !== exp_addr_q[0] || wdata_o !== exp_data_q[0]) begin
                errors++;
                $display("FAIL hold_stable: we=%b addr=%h wdata=%h, required 1 %h %h",
                         we_o, addr_o, wdata_o, exp_addr_q[0], exp_data_q[0]);
            end
        end
        fixed_ready = 1'b1;
        ref_encode(7, 0, 0, 9, 0, 0, 32'h12345000, ok, w);
        send(7, 0, 0, 9, 0, 0, 32'h12345000, 1, ok, w);
        wait_done("backpressure");
    endtask

    task automatic test_reject;
        bit ok;
        logic [31:0] w;
        fixed_ready = 1'b1;
        do_start(12'h300);
        send(1, 0, 0, 1, 0, 0, 4096, 0, 0, 32'h0);
        @(negedge clk_i);
        checks++;
        if (err_o !== 1'b1 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL reject_imm: err=%b we=%b, required 1 0", err_o, we_o);
        end
        send(1, 1, 0, 2, 3, 0, 3, 0, 0, 32'h0);
        send(0, 4, 0, 2, 3, 4, 0, 0, 0, 32'h0);
        send(4, 0, 0, 0, 1, 2, 5, 0, 0, 32'h0);
        send(7, 0, 0, 4, 0, 0, 32'h0000_1001, 0, 0, 32'h0);
        send(1, 6, 0, 4, 5, 0, 32, 0, 0, 32'h0);
        ref_encode(0, 0, 0, 8, 9, 10, 0, ok, w);
        send(0, 0, 0, 8, 9, 10, 0, 1, ok, w);
        wait_done("reject");
        checks++;
        if (err_o !== 1'b1 || addr_o !== 12'h304) begin
            errors++;
            $display("FAIL reject_sticky: err=%b addr=%h, required 1 304", err_o, addr_o);
        end
        do_start(12'h000);
        ref_encode(1, 6, 0, 1, 2, 0, 31, ok, w);
        send(1, 6, 0, 1, 2, 0, 31, 1, ok, w);
        wait_done("reject_restart");
    endtask

    task automatic test_random;
        int edges[14] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097,
                          1048575, 1048576, -1048576, -1048577, 31, 32};
        int cls, alu, imm;
        bit ok;
        logic [31:0] w;
        rand_mode = 1'b1;
        do_start(12'hFF0);
        for (int i = 0; i < 40; i++) begin
            cls = int'($urandom_range(0, 7));
            alu = int'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       imm = int'($urandom_range(0, 63)) - 32;
                1:       imm = int'($urandom);
                2:       imm = edges[$urandom_range(0, 13)];
                3:       imm = int'($urandom & 32'hFFFF_F000);
                4:       imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                default: imm = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            endcase
            ref_encode(cls, alu, int'($urandom_range(0, 7)), 0, 0, 0, 0, ok, w);
            begin
                int f3, rd, rs1, rs2;
                f3  = int'($urandom_range(0, 7));
                rd  = int'($urandom_range(0, 31));
                rs1 = int'($urandom_range(0, 31));
                rs2 = int'($urandom_range(0, 31));
                ref_encode(cls, alu, f3, rd, rs1, rs2, imm, ok, w);
                send(cls, alu, f3, rd, rs1, rs2, imm, i == 39, ok, w);
            end
        end
        wait_done("random");
        checks++;
        if (err_o !== exp_err || addr_o !== exp_addr) begin
            errors++;
            $display("FAIL random_end: err=%b addr=%h, required %b %h", err_o, addr_o, exp_err, exp_addr);
        end
        rand_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [31:0] w;
        fixed_ready = 1'b0;
        do_start(12'h040);
        for (int k = 0; k < 2; k++) begin
            ref_encode(0, 3, 0, k + 1, 1, 2, 0, ok, w);
            send(0, 3, 0, k + 1, 1, 2, 0, 0, ok, w);
        end
        @(negedge clk_i);
        checks++;
        if (we_o !== 1'b1) begin
            errors++;
            $display("FAIL two_held: we=%b, required 1", we_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (we_o !== 0 || ready_o !== 0 || busy_o !== 0 || done_o !== 0 || addr_o !== 0 ||
            wdata_o !== 0) begin
            errors++;
            $display("FAIL mid_reset: we=%b ready=%b busy=%b done=%b addr=%h wdata=%h, required all 0",
                     we_o, ready_o, busy_o, done_o, addr_o, wdata_o);
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        fixed_ready = 1'b1;
        repeat (6) @(negedge clk_i);
        checks++;
        if (we_o !== 0 || busy_o !== 0 || done_o !== 0) begin
            errors++;
            $display("FAIL after_abort: we=%b busy=%b done=%b, required 0 0 0", we_o, busy_o, done_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reject();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
